// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage RV32I pipeline: tracks register-use metadata
// for E/M/W, and drives forwarding selects, stall/flush/freeze and debug counters.
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rd_D,
  input  logic              RegWrite_D,
  input  logic [1:0]        ResultSrc_D,
  input  logic              PCSrc_E,
  input  logic              MemStall_M,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              StallX,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  br_flush_cnt
);

  localparam logic [1:0]       SRC_LOAD = 2'b01;
  localparam logic [1:0]       FWD_RD   = 2'b00;
  localparam logic [1:0]       FWD_W    = 2'b01;
  localparam logic [1:0]       FWD_M    = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [REG_AW-1:0] r_rs1E, r_rs2E, r_rdE, r_rdM, r_rdW;
  logic              r_regWriteE, r_regWriteM, r_regWriteW;
  logic [1:0]        r_resultSrcE, r_resultSrcM;
  logic [CNT_W-1:0]  r_luCnt, r_brCnt;

  logic       w_lwStall;
  logic       w_flushE;
  logic [1:0] w_fwdA, w_fwdB;
  logic       w_mValid, w_wValid;

  // Loads in M are not forwardable; the data only exists once it reaches W.
  assign w_mValid  = r_regWriteM && (r_rdM != '0) && (r_resultSrcM != SRC_LOAD);
  assign w_wValid  = r_regWriteW && (r_rdW != '0);
  assign w_lwStall = r_regWriteE && (r_resultSrcE == SRC_LOAD) && (r_rdE != '0) &&
                     ((Rs1_D == r_rdE) || (Rs2_D == r_rdE));
  assign w_flushE  = PCSrc_E || w_lwStall;

  always_comb begin
    w_fwdA = FWD_RD;
    w_fwdB = FWD_RD;
    if (w_mValid && (r_rdM == r_rs1E))      w_fwdA = FWD_M;
    else if (w_wValid && (r_rdW == r_rs1E)) w_fwdA = FWD_W;
    if (w_mValid && (r_rdM == r_rs2E))      w_fwdB = FWD_M;
    else if (w_wValid && (r_rdW == r_rs2E)) w_fwdB = FWD_W;
  end

  // Priority: reset, then memory freeze, then taken branch, then load-use.
  always_comb begin
    ForwardA_E = w_fwdA;
    ForwardB_E = w_fwdB;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    StallX     = 1'b0;
    if (rst) begin
      ForwardA_E = FWD_RD;
      ForwardB_E = FWD_RD;
      FlushD     = 1'b1;
      FlushE     = 1'b1;
    end else if (MemStall_M) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallX = 1'b1;
    end else if (PCSrc_E) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_lwStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1E       <= '0;
      r_rs2E       <= '0;
      r_rdE        <= '0;
      r_regWriteE  <= 1'b0;
      r_resultSrcE <= '0;
      r_rdM        <= '0;
      r_regWriteM  <= 1'b0;
      r_resultSrcM <= '0;
      r_rdW        <= '0;
      r_regWriteW  <= 1'b0;
      r_luCnt      <= '0;
      r_brCnt      <= '0;
    end else if (!MemStall_M) begin
      r_rdW        <= r_rdM;
      r_regWriteW  <= r_regWriteM;
      r_rdM        <= r_rdE;
      r_regWriteM  <= r_regWriteE;
      r_resultSrcM <= r_resultSrcE;
      if (w_flushE) begin
        r_rs1E       <= '0;
        r_rs2E       <= '0;
        r_rdE        <= '0;
        r_regWriteE  <= 1'b0;
        r_resultSrcE <= '0;
      end else begin
        r_rs1E       <= Rs1_D;
        r_rs2E       <= Rs2_D;
        r_rdE        <= Rd_D;
        r_regWriteE  <= RegWrite_D;
        r_resultSrcE <= ResultSrc_D;
      end
      if (w_lwStall && !PCSrc_E && (r_luCnt != CNT_MAX)) r_luCnt <= r_luCnt + CNT_ONE;
      if (PCSrc_E && (r_brCnt != CNT_MAX))               r_brCnt <= r_brCnt + CNT_ONE;
    end
  end

  assign lu_stall_cnt = r_luCnt;
  assign br_flush_cnt = r_brCnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed per-cycle vectors push their
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_hazard_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  Rs1_D = '0, Rs2_D = '0, Rd_D = '0;
  logic        RegWrite_D = 1'b0;
  logic [1:0]  ResultSrc_D = '0;
  logic        PCSrc_E = 1'b0, MemStall_M = 1'b0;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        StallF, StallD, FlushD, FlushE, StallX;
  logic [31:0] lu_stall_cnt, br_flush_cnt;

  hazard_ctrl_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D), .PCSrc_E(PCSrc_E),
    .MemStall_M(MemStall_M), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallX(StallX), .lu_stall_cnt(lu_stall_cnt), .br_flush_cnt(br_flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl bit order: {StallF, StallD, FlushD, FlushE, StallX}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_FLSH = 5'b00110;
  localparam logic [4:0] C_LU   = 5'b11010;
  localparam logic [4:0] C_MEM  = 5'b11001;

  typedef struct {
    string       name;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [4:0]  ctl;
    logic [31:0] lu;
    logic [31:0] br;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  task automatic applyStimulus(input logic r, input logic ms, input logic pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rw, input logic [1:0] src);
    @(posedge clk);
    #1;
    rst = r; MemStall_M = ms; PCSrc_E = pc;
    Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd; RegWrite_D = rw; ResultSrc_D = src;
  endtask

  task automatic expectOutput(input string name, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [4:0] ctl, input logic [31:0] lu, input logic [31:0] br);
    exp_t e;
    e.name = name; e.fa = fa; e.fb = fb; e.ctl = ctl; e.lu = lu; e.br = br;
    sb.push_back(e);
  endtask

  task automatic step(input string name, input logic r, input logic ms, input logic pc,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic [1:0] src,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] ctl,
                      input logic [31:0] lu, input logic [31:0] br);
    applyStimulus(r, ms, pc, rs1, rs2, rd, rw, src);
    expectOutput(name, fa, fb, ctl, lu, br);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] ctl;
    ctl = {StallF, StallD, FlushD, FlushE, StallX};
    checks++;
    if ({ForwardA_E, ForwardB_E} !== {e.fa, e.fb}) begin
      errors++;
      $display("[TB] FAIL %s fwd: got A=%b B=%b expected A=%b B=%b",
               e.name, ForwardA_E, ForwardB_E, e.fa, e.fb);
    end
    checks++;
    if (ctl !== e.ctl) begin
      errors++;
      $display("[TB] FAIL %s ctl{StF,StD,FlD,FlE,StX}: got %b expected %b", e.name, ctl, e.ctl);
    end
    checks++;
    if ({lu_stall_cnt, br_flush_cnt} !== {e.lu, e.br}) begin
      errors++;
      $display("[TB] FAIL %s cnt: got lu=%0d br=%0d expected lu=%0d br=%0d",
               e.name, lu_stall_cnt, br_flush_cnt, e.lu, e.br);
    end
  endtask

  // Monitor: every cycle, compare against the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("[TB] FAIL watchdog: got no completion expected completion");
      $fatal(1, "[TB] timeout");
    end
  end

  initial begin
    //    name        rst ms pc rs1 rs2 rd rw src   fA     fB     ctl     lu br
    step("rst0",      1, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_FLSH, 0, 0);
    step("rst1",      1, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_FLSH, 0, 0);
    step("addx5",     0, 0, 0,  1,  2,  5, 1, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    step("subx5",     0, 0, 0,  5,  3,  8, 1, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    step("exex",      0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b10, 2'b00, C_NONE, 0, 0);
    step("addx5b",    0, 0, 0,  1,  2,  5, 1, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    step("andx6",     0, 0, 0,  1,  2,  6, 1, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    step("orx5x5",    0, 0, 0,  5,  5,  9, 1, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    step("memex",     0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b01, 2'b01, C_NONE, 0, 0);
    step("addx5c",    0, 0, 0,  1,  2,  5, 1, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    step("addix5",    0, 0, 0,  5,  0,  5, 1, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    step("rs2x0",     0, 0, 0,  5,  5, 10, 1, 2'b00, 2'b10, 2'b00, C_NONE, 0, 0);
    step("mOverW",    0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b10, 2'b10, C_NONE, 0, 0);
    step("lwx7",      0, 0, 0,  1,  0,  7, 1, 2'b01, 2'b00, 2'b00, C_NONE, 0, 0);
    step("luStall",   0, 0, 0,  1,  7, 11, 1, 2'b00, 2'b00, 2'b00, C_LU,   0, 0);
    step("luReplay",  0, 0, 0,  1,  7, 11, 1, 2'b00, 2'b00, 2'b00, C_NONE, 1, 0);
    step("luFwdW",    0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b01, C_NONE, 1, 0);
    step("branch",    0, 0, 1, 11,  0, 12, 1, 2'b00, 2'b00, 2'b00, C_FLSH, 1, 0);
    step("postBr",    0, 0, 0, 12, 12, 13, 1, 2'b00, 2'b00, 2'b00, C_NONE, 1, 1);
    step("bubble",    0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 1, 1);
    step("lwx14",     0, 0, 0,  1,  0, 14, 1, 2'b01, 2'b00, 2'b00, C_NONE, 1, 1);
    step("brOverLu",  0, 0, 1, 14,  0, 15, 1, 2'b00, 2'b00, 2'b00, C_FLSH, 1, 1);
    step("afterBrLu", 0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 1, 2);
    step("addx16",    0, 0, 0,  1,  2, 16, 1, 2'b00, 2'b00, 2'b00, C_NONE, 1, 2);
    step("usex16",    0, 0, 0, 16, 16, 17, 1, 2'b00, 2'b00, 2'b00, C_NONE, 1, 2);
    step("memWait1",  0, 1, 0,  0,  0,  0, 0, 2'b00, 2'b10, 2'b10, C_MEM,  1, 2);
    step("memWait2",  0, 1, 1,  0,  0,  0, 0, 2'b00, 2'b10, 2'b10, C_MEM,  1, 2);
    step("memWait3",  0, 1, 0,  0,  0,  0, 0, 2'b00, 2'b10, 2'b10, C_MEM,  1, 2);
    step("memResume", 0, 0, 0, 16, 17, 18, 1, 2'b00, 2'b10, 2'b10, C_NONE, 1, 2);
    step("memAfter",  0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b01, 2'b10, C_NONE, 1, 2);
    step("wrx0",      0, 0, 0,  1,  2,  0, 1, 2'b00, 2'b00, 2'b00, C_NONE, 1, 2);
    step("lwx0",      0, 0, 0,  0,  0,  0, 1, 2'b01, 2'b00, 2'b00, C_NONE, 1, 2);
    step("rdx0",      0, 0, 0,  0,  0, 19, 1, 2'b00, 2'b00, 2'b00, C_NONE, 1, 2);
    step("rdx0b",     0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 1, 2);
    step("usex19",    0, 0, 0, 19, 19, 20, 1, 2'b00, 2'b00, 2'b00, C_NONE, 1, 2);
    step("midRst",    1, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_FLSH, 1, 2);
    step("midRst2",   1, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_FLSH, 0, 0);
    step("postRst",   0, 0, 0,  0,  0,  0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
